// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: sync_fifo read master re-presenting words on a valid/ready stream; FIFO_RD_BURST_EN gates reads into bursts
module fifo_stream_reader #(
   parameter int FIFO_WIDTH     = 16,
   parameter int FIFO_SIZE_BITS = 5,
   parameter int BURST_LEN      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      fifo_rd,
   input  logic [FIFO_WIDTH-1:0]     fifo_data,
   input  logic                      fifo_empty,
   input  logic [FIFO_SIZE_BITS-1:0] fifo_counter,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [FIFO_WIDTH-1:0]     m_data,
   output logic [15:0]               words_sent
);
   localparam logic [FIFO_SIZE_BITS-1:0] BL = FIFO_SIZE_BITS'(BURST_LEN);
   logic [FIFO_WIDTH-1:0] buf_q [3];
   logic [FIFO_WIDTH-1:0] buf_nx [3];
   logic [1:0] buf_count, wr_idx;
   logic inflight, run, issue_ok, push, pop;
   assign push    = inflight;
   assign pop     = m_valid && m_ready;
   assign m_valid = buf_count != 2'd0;
   assign m_data  = buf_q[0];
   assign wr_idx  = buf_count - {1'b0, pop};
   assign fifo_rd = run && issue_ok && !fifo_empty && (({1'b0, buf_count} + {2'b0, inflight}) < 3'd3);
   // buffer next contents: shift the head out on pop, land the returning word behind the survivors
   always_comb begin
      buf_nx = buf_q;
      if (pop) buf_nx = '{buf_q[1], buf_q[2], buf_q[2]};
      if (push) buf_nx[wr_idx] = fifo_data;
   end
   // buffer, occupancy, read-in-flight flag, post-reset read enable and accepted-word counter
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q      <= '{default: '0};
         buf_count  <= 2'd0;
         inflight   <= 1'b0;
         run        <= 1'b0;
         words_sent <= 16'd0;
      end else begin
         assert (!(push && !pop && buf_count == 2'd3));
         buf_q      <= buf_nx;
         buf_count  <= buf_count + {1'b0, push} - {1'b0, pop};
         inflight   <= fifo_rd;
         run        <= 1'b1;
         words_sent <= words_sent + {15'd0, pop};
      end
   end
`ifdef FIFO_RD_BURST_EN
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_nx;
   logic [FIFO_SIZE_BITS-1:0] burst_left, burst_left_nx;
   assign issue_ok = state == BURST;
   // burst FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         burst_left <= '0;
      end else begin
         state      <= state_nx;
         burst_left <= burst_left_nx;
      end
   end
   // arm a burst once a full burst is queued, count issued reads down to the last one
   always_comb begin
      state_nx      = state;
      burst_left_nx = burst_left;
      if (state == IDLE && fifo_counter >= BL) begin
         state_nx      = BURST;
         burst_left_nx = BL;
      end
      if (state == BURST && fifo_rd) begin
         burst_left_nx = burst_left - 1'b1;
         state_nx      = (burst_left == FIFO_SIZE_BITS'(1)) ? IDLE : BURST;
      end
   end
`else
   logic unused_cfg;
   assign issue_ok   = 1'b1;
   assign unused_cfg = ^{fifo_counter, BL};
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and random checks of fifo_stream_reader against a behavioural sync_fifo and stream scoreboard
module tb_fifo_stream_reader;
   logic clk = 1'b0, reset = 1'b1, fifo_clr = 1'b1, wr = 1'b0, m_ready = 1'b0;
   logic [15:0] wdata = '0, fifo_data = '0, m_data, words_sent;
   logic fifo_rd, m_valid, fifo_empty = 1'b1;
   logic [4:0] fifo_counter = '0;
   logic [15:0] q[$], exp_q[$];
   int bt_cyc[$];
   int checks = 0, failures = 0;
   int underflows = 0, reads = 0, beats = 0, rd_sr = 0, bt_sr = 0, cyc = 0, ws_model = 0, first_rd = -1;
   int r0, b0;
   logic prev_hold = 1'b0;
   logic [15:0] prev_data = '0;

   always #5 clk = ~clk;

   fifo_stream_reader dut (
      .clk(clk), .reset(reset), .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_counter(fifo_counter), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .words_sent(words_sent)
   );

   // behavioural sync_fifo: data_out one cycle after a sampled read, registered occupancy
   always @(posedge clk) begin
      if (fifo_clr) q.delete();
      else begin
         if (fifo_rd) begin
            if (q.size() == 0) underflows++;
            else fifo_data <= q.pop_front();
         end
         if (wr) q.push_back(wdata);
      end
      fifo_empty   <= q.size() == 0;
      fifo_counter <= 5'(q.size());
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      logic r = reset;
      logic [31:0] e;
      if (!r) begin
         if (prev_hold) begin
            chk("hold_valid", {31'd0, m_valid}, 1);
            chk("hold_data", {16'd0, m_data}, {16'd0, prev_data});
         end
         if (fifo_rd) begin
            chk("rd_when_empty", {31'd0, fifo_empty}, 0);
            reads++; rd_sr++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (m_valid && m_ready) begin
            e = 32'hxxxxxxxx;
            if (exp_q.size() > 0) e = {16'd0, exp_q.pop_front()};
            chk("beat_data", {16'd0, m_data}, e);
            beats++; bt_sr++;
            ws_model = (ws_model + 1) % 65536;
            bt_cyc.push_back(cyc);
         end
         chk("credit", {31'd0, (rd_sr - bt_sr) <= 3}, 1);
      end
      prev_hold = m_valid && !m_ready && !r;
      prev_data = m_data;
      if (fifo_clr) exp_q.delete();
      else if (wr) exp_q.push_back(wdata);
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         ws_model = 0; rd_sr = 0; bt_sr = 0; prev_hold = 1'b0;
      end
      chk("words_sent", {16'd0, words_sent}, ws_model);
   endtask

   task automatic put(input logic [15:0] d);
      wr = 1'b1; wdata = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
      chk("drained", exp_q.size(), 0);
   endtask

   task automatic rst_outs(input string tag);
      chk({tag, "_rd"}, {31'd0, fifo_rd}, 0);
      chk({tag, "_valid"}, {31'd0, m_valid}, 0);
      chk({tag, "_data"}, {16'd0, m_data}, 0);
      chk({tag, "_ws"}, {16'd0, words_sent}, 0);
   endtask

   initial begin
      // reset held 5 cycles while the FIFO holds 3 words
      tick();
      fifo_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rst_outs("rst_hold");
         put(16'h0100 + 16'(i));
      end
      rst_outs("rst_hold");
      tick();
      reset = 1'b0;
      rst_outs("rst_release");
      chk("rst_fifo_cnt", {27'd0, fifo_counter}, 3);
`ifndef FIFO_RD_BURST_EN
      m_ready = 1'b1;
      drain(20);
      // streaming 32 words with a permanently ready sink
      first_rd = -1; bt_cyc.delete();
      for (int i = 0; i < 32; i++) put(16'(i));
      drain(20);
      chk("stream_count", bt_cyc.size(), 32);
      if (bt_cyc.size() == 32) begin
         chk("stream_latency", bt_cyc[0] - first_rd, 2);
         for (int i = 1; i < 32; i++) chk("stream_b2b", bt_cyc[i] - bt_cyc[i-1], 1);
      end
      chk("stream_words_sent", {16'd0, words_sent}, 35);
      chk("stream_empty", {31'd0, fifo_empty}, 1);
      // backpressure with 10 words queued
      m_ready = 1'b0; r0 = reads; b0 = beats;
      for (int i = 0; i < 10; i++) put(16'h0200 + 16'(i));
      repeat (5) tick();
      chk("bp_reads", reads - r0, 3);
      chk("bp_counter", {27'd0, fifo_counter}, 7);
      chk("bp_valid", {31'd0, m_valid}, 1);
      chk("bp_data", {16'd0, m_data}, 32'h0200);
      m_ready = 1'b1;
      drain(40);
      chk("bp_count", beats - b0, 10);
`else
      reset = 1'b1; fifo_clr = 1'b1;
      tick();
      reset = 1'b0; fifo_clr = 1'b0;
      tick();
`endif
      // empty FIFO with a ready sink
      m_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         chk("empty_rd", {31'd0, fifo_rd}, 0);
         chk("empty_valid", {31'd0, m_valid}, 0);
         tick();
      end
      chk("empty_underflow", underflows, 0);
`ifndef FIFO_RD_BURST_EN
      // reset in the cycle a read issues with two words buffered
      m_ready = 1'b0;
      put(16'h0300); put(16'h0301);
      repeat (4) tick();
      chk("mid_buffered", {31'd0, m_valid}, 1);
      put(16'h0302);
      for (int i = 0; i < 5 && !fifo_rd; i++) tick();
      chk("mid_rd_seen", {31'd0, fifo_rd}, 1);
      reset = 1'b1; fifo_clr = 1'b1;
      tick();
      reset = 1'b0; fifo_clr = 1'b0;
      rst_outs("mid_rst");
      m_ready = 1'b1; bt_cyc.delete();
      put(16'hA5A5); put(16'h5A5A);
      drain(20);
      chk("mid_count", bt_cyc.size(), 2);
      // random writes and sink stalls against the scoreboard
      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 2) != 0) && (fifo_counter < 5'd28);
         wdata = 16'($urandom);
         m_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      wr = 1'b0; m_ready = 1'b1;
      drain(100);
      chk("rand_underflow", underflows, 0);
`else
      // burst gating: nothing below the threshold, exactly one burst above it
      r0 = reads;
      for (int i = 0; i < 7; i++) put(16'h0400 + 16'(i));
      repeat (10) tick();
      chk("burst_below_reads", reads - r0, 0);
      put(16'h0407);
      repeat (20) tick();
      chk("burst_reads", reads - r0, 8);
      chk("burst_counter", {27'd0, fifo_counter}, 0);
      chk("burst_delivered", exp_q.size(), 0);
      r0 = reads; b0 = beats;
      for (int i = 0; i < 12; i++) put(16'h0500 + 16'(i));
      repeat (30) tick();
      chk("burst12_reads", reads - r0, 8);
      chk("burst12_beats", beats - b0, 8);
      chk("burst12_counter", {27'd0, fifo_counter}, 4);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
